// File: rtl/cram_pingpong.sv
// Ping-pong complex-sample RAM: the producer fills one bank while the consumer reads the other.
// A swap_req/swap_ack handshake exchanges the banks. Optional macro CRAM_BITREV_EN adds bit-reversed write addressing.
module cram_pingpong #(
    parameter  int vector_size = 16,
    parameter  int N           = 32,
    localparam int AW          = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
`ifdef CRAM_BITREV_EN
    input  logic                   bitrev_wr,
`endif
    input  logic [vector_size-1:0] in_real,
    input  logic [vector_size-1:0] in_im,
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_addr,
    output logic [vector_size-1:0] out_real,
    output logic [vector_size-1:0] out_im,
    output logic                   out_valid,
    input  logic                   swap_req,
    output logic                   swap_ack,
    output logic                   wr_bank,
    output logic [AW:0]            wr_count,
    output logic                   full
);

    localparam int          DW         = 2 * vector_size;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(N);

    typedef enum logic {
        RUN  = 1'b0,
        SWAP = 1'b1
    } state_e;

    state_e state_q, state_d;

    // Both banks live in one array; the bank index is the address MSB.
    logic [DW-1:0] mem_q [2*N];

    logic                   wr_bank_q, wr_bank_d;
    logic [AW:0]            wr_count_q, wr_count_d;
    logic                   swap_ack_q, swap_ack_d;
    logic                   out_valid_q, out_valid_d;
    logic [vector_size-1:0] out_real_q, out_real_d;
    logic [vector_size-1:0] out_im_q, out_im_d;

    logic                   mem_we;
    logic                   rd_fire;
    logic                   swap_done;
    logic [AW-1:0]          wr_phys_addr;
    logic [DW-1:0]          rd_word;

`ifdef CRAM_BITREV_EN
    function automatic logic [AW-1:0] bit_reverse(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    assign wr_phys_addr = bitrev_wr ? bit_reverse(wr_addr) : wr_addr;
`else
    assign wr_phys_addr = wr_addr;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // FSM: next state; SWAP always lasts exactly one cycle and ignores swap_req.
    always_comb begin
        // NOTE: default first so no path through the block leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            RUN:     if (swap_req) state_d = SWAP;
            SWAP:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM: outputs; accesses are honoured only in RUN, including the edge that enters SWAP.
    always_comb begin
        mem_we    = 1'b0;
        rd_fire   = 1'b0;
        swap_done = 1'b0;
        unique case (state_q)
            RUN: begin
                mem_we  = wr_en;
                rd_fire = rd_en;
            end
            SWAP:    swap_done = 1'b1;
            default: ;
        endcase
    end

    assign rd_word = mem_q[{~wr_bank_q, rd_addr}];

    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_count_d  = wr_count_q;
        swap_ack_d  = swap_done;
        out_valid_d = rd_fire;
        out_real_d  = out_real_q;
        out_im_d    = out_im_q;

        if (swap_done) begin
            wr_bank_d  = ~wr_bank_q;
            wr_count_d = '0;
        end else if (mem_we && (wr_count_q != FULL_COUNT)) begin
            wr_count_d = wr_count_q + 1'b1;
        end

        if (rd_fire) begin
            out_real_d = rd_word[DW-1:vector_size];
            out_im_d   = rd_word[vector_size-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            wr_count_q  <= '0;
            swap_ack_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_real_q  <= '0;
            out_im_q    <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_count_q  <= wr_count_d;
            swap_ack_q  <= swap_ack_d;
            out_valid_q <= out_valid_d;
            out_real_q  <= out_real_d;
            out_im_q    <= out_im_d;
        end
    end

    // NOTE: storage has no reset so it maps onto RAM; reads of unwritten words are undefined.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[{wr_bank_q, wr_phys_addr}] <= {in_real, in_im};
        end
    end

    assign out_real  = out_real_q;
    assign out_im    = out_im_q;
    assign out_valid = out_valid_q;
    assign swap_ack  = swap_ack_q;
    assign wr_bank   = wr_bank_q;
    assign wr_count  = wr_count_q;
    assign full      = (wr_count_q == FULL_COUNT);

endmodule

// File: tb/tb_cram_pingpong.sv
// Scoreboard bench for cram_pingpong (N=8): reads push expected words, a negedge monitor pops on out_valid.
module tb_cram_pingpong;

    localparam int VS = 16;
    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
`ifdef CRAM_BITREV_EN
    logic          bitrev_wr;
`endif
    logic [VS-1:0] in_real, in_im;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [VS-1:0] out_real, out_im;
    logic          out_valid;
    logic          swap_req;
    logic          swap_ack;
    logic          wr_bank;
    logic [AW:0]   wr_count;
    logic          full;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    cram_pingpong #(.vector_size(VS), .N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
`ifdef CRAM_BITREV_EN
        .bitrev_wr(bitrev_wr),
`endif
        .in_real  (in_real),
        .in_im    (in_im),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .out_real (out_real),
        .out_im   (out_im),
        .out_valid(out_valid),
        .swap_req (swap_req),
        .swap_ack (swap_ack),
        .wr_bank  (wr_bank),
        .wr_count (wr_count),
        .full     (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest outstanding expected read.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read: got 0x%04h%04h expected no valid", out_real, out_im);
            end else begin
                check("read_data", {out_real, out_im}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [VS-1:0] re, input logic [VS-1:0] im);
        wr_en = 1'b1; wr_addr = a; in_real = re; in_im = im;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [31:0] exp);
        rd_en = 1'b1; rd_addr = a;
        exp_q.push_back(exp);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_swap(input logic exp_bank);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tick();
        check("swap_ack_pulse", {31'b0, swap_ack}, 32'd1);
        check("swap_bank", {31'b0, wr_bank}, {31'b0, exp_bank});
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; in_real = '0; in_im = '0;
        rd_en = 1'b0; rd_addr = '0; swap_req = 1'b0;
`ifdef CRAM_BITREV_EN
        bitrev_wr = 1'b0;
`endif
        repeat (3) tick();
        check("rst_out_data", {out_real, out_im}, 32'h0);
        check("rst_flags", {28'b0, out_valid, swap_ack, wr_bank, full}, 32'h0);
        check("rst_wr_count", {28'b0, wr_count}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Write bank 0, swap with a write/read attempted during SWAP, read back.
        do_write(3'd3, 16'h1234, 16'hABCD);
        check("count_after_one", {28'b0, wr_count}, 32'd1);
        swap_req = 1'b1;
        tick();
        check("swap_k_ack", {31'b0, swap_ack}, 32'd0);
        check("swap_k_bank", {31'b0, wr_bank}, 32'd0);
        swap_req = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd3; in_real = 16'hDEAD; in_im = 16'hDEAD;
        rd_en = 1'b1; rd_addr = 3'd3;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("swap_k1_ack", {31'b0, swap_ack}, 32'd1);
        check("swap_k1_bank", {31'b0, wr_bank}, 32'd1);
        check("swap_k1_count", {28'b0, wr_count}, 32'd0);
        check("swap_k1_no_valid", {31'b0, out_valid}, 32'd0);
        do_read(3'd3, 32'h1234ABCD);
        check("ack_one_cycle", {31'b0, swap_ack}, 32'd0);
        tick();
        check("data_hold", {out_real, out_im}, 32'h1234ABCD);
        check("valid_drops", {31'b0, out_valid}, 32'd0);

        // Fill bank 1, then overwrite while full.
        for (int i = 0; i < N; i++) begin
            if (i == 5) do_write(3'd5, 16'h7777, 16'h7777);
            else        do_write(AW'(i), 16'h0010 + VS'(i), 16'h0020 + VS'(i));
            if (i == N - 2) check("not_full_at_7", {27'b0, full, wr_count}, 32'h07);
        end
        check("full_at_8", {27'b0, full, wr_count}, 32'h18);
        do_write(3'd0, 16'h0009, 16'h0009);
        check("full_saturate", {27'b0, full, wr_count}, 32'h18);
        do_swap(1'b0);
        do_read(3'd0, 32'h00090009);
        do_read(3'd7, 32'h00170027);

        // Concurrent write bank 0 / read bank 1 at the same address.
        wr_en = 1'b1; wr_addr = 3'd5; in_real = 16'h0505; in_im = 16'h0505;
        rd_en = 1'b1; rd_addr = 3'd5;
        exp_q.push_back(32'h77777777);
        tick();
        wr_en = 1'b0;
        // Read on the edge entering SWAP sees the old read bank; the SWAP-cycle read is dropped.
        swap_req = 1'b1;
        exp_q.push_back(32'h77777777);
        tick();
        swap_req = 1'b0;
        tick();
        rd_en = 1'b0;
        check("concurrent_swap_bank", {31'b0, wr_bank}, 32'd1);
        do_read(3'd5, 32'h05050505);

        // Held swap_req from bank 0: acks on alternate edges.
        do_swap(1'b0);
        tick();
        pulses = 0;
        swap_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("held_ack", {31'b0, swap_ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
            pulses += int'(swap_ack);
        end
        swap_req = 1'b0;
        tick();
        check("held_ack_after", {31'b0, swap_ack}, 32'd0);
        check("held_pulses", pulses, 32'd3);
        check("held_bank", {31'b0, wr_bank}, 32'd1);

`ifdef CRAM_BITREV_EN
        // Bit-reversed write of addr 1 lands at physical 4 in bank 1.
        bitrev_wr = 1'b1;
        do_write(3'd1, 16'h00AA, 16'h0055);
        bitrev_wr = 1'b0;
        check("bitrev_count", {28'b0, wr_count}, 32'd1);
        do_swap(1'b0);
        do_read(3'd4, 32'h00AA0055);
        do_read(3'd1, 32'h00110021);
`endif

        // Reset in the middle of SWAP aborts it.
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midswap_rst_bank", {31'b0, wr_bank}, 32'd0);
        check("midswap_rst_flags", {27'b0, swap_ack, wr_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("midswap_no_ack", {30'b0, swap_ack, wr_bank}, 32'd0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        check("scoreboard_drain", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cram_pingpong.md
Name: cram_pingpong

Overview:
- Double-buffered (ping-pong) complex-sample RAM for inter-stage storage in the FFT datapath.
- The producer writes one bank while the consumer reads the other. A request/acknowledge swap exchanges the banks between FFT passes.
- Each word holds {real, imaginary}, 2*vector_size bits, real in the upper half.
- Reads are registered with a valid flag, and a fill counter reports when the write bank is full.

Parameters:
- vector_size, 16, width of each real/imaginary component (signed Q format; the block treats it as opaque).
- N, 32, words per bank; must be a power of two, minimum 2.
- AW, $clog2(N), address width; derived, do not override.

Ports:
- clk  input  1  system clock, all logic on the rising edge
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  write strobe into the current write bank
- wr_addr  input  AW  write address
- in_real  input  vector_size  real part of the write data
- in_im  input  vector_size  imaginary part of the write data
- rd_en  input  1  read strobe from the current read bank
- rd_addr  input  AW  read address
- out_real  output  vector_size  registered real read data
- out_im  output  vector_size  registered imaginary read data
- out_valid  output  1  high for one cycle when out_real/out_im carry new data
- swap_req  input  1  level request to exchange the banks
- swap_ack  output  1  one-cycle pulse on the cycle the banks have swapped
- wr_bank  output  1  index of the bank currently written; the read bank is ~wr_bank
- wr_count  output  AW+1  accepted writes since the last swap or reset, saturating at N
- full  output  1  wr_count == N

Behaviour:
- Storage: two arrays of N x 2*vector_size words. Contents are not reset.
- Reset (asynchronous, rst_n=0) drives:
  - wr_bank=0, state=RUN
  - out_real=0, out_im=0, out_valid=0
  - swap_ack=0, wr_count=0, full=0
- Reset asserted mid-operation aborts any swap immediately.
- State RUN:
  - wr_en=1: memory[wr_bank][wr_addr] <= {in_real,in_im} at the clock edge. wr_count increments, saturating at N.
  - Writes while full are still performed (overwrite allowed); wr_count stays at N.
  - rd_en=1: on the next edge out_real/out_im <= memory[~wr_bank][rd_addr] and out_valid <= 1. Otherwise out_valid <= 0 and the data outputs hold.
  - Read latency is exactly 1 cycle.
  - Read and write always target different banks, so same-address simultaneous access has no hazard.
  - swap_req=1 sampled at an edge in RUN: go to SWAP. wr_en and rd_en are still honoured on that same edge.
- State SWAP (exactly one cycle):
  - wr_en and rd_en are ignored: no memory write, out_valid <= 0.
  - At the end of the cycle: wr_bank toggles, wr_count <= 0, swap_ack <= 1 for one cycle, return to RUN.
- swap_req:
  - It is a level. Sampling resumes in RUN the cycle after swap_ack.
  - A requester that holds it high gets back-to-back swaps every 2 cycles.
  - swap_req during SWAP is ignored.
- A read issued on the edge that enters SWAP returns old read-bank data on the following cycle, because capture precedes the toggle.
- Timeline for a request first seen at edge k:
  - Edge k+1: bank toggles, swap_ack and wr_bank update.
  - The first write/read on the new banks is accepted at edge k+2.

Optional Feature:
- Macro: CRAM_BITREV_EN.
- Defined:
  - Adds input port bitrev_wr (1 bit, placed after wr_addr).
  - When bitrev_wr=1, the physical write address is wr_addr with its AW bits reversed (bit i -> bit AW-1-i). When 0, the address is direct.
  - Reads are never reversed.
  - wr_count and full are unaffected.
- Undefined: the port is absent and all write addresses are direct.

Test Plan:
- Reset/readback, N=8:
  - rst_n low -> all outputs 0, wr_bank=0.
  - Write addr 3 = {0x1234, 0xABCD}, then swap, then read addr 3 -> next cycle out_real=0x1234, out_im=0xABCD, out_valid=1.
- Fill/full, N=8:
  - 8 writes -> wr_count=8, full=1.
  - 9th write to addr 0 with {0x0009,0x0009} -> wr_count stays 8; after swap, read 0 returns 0x0009.
- Swap timing:
  - swap_req=1 for one cycle at edge k -> swap_ack=1 and wr_bank=1 after edge k+1 only.
  - wr_en asserted during SWAP -> no memory change; wr_count=0 after swap.
- Concurrent access:
  - Write bank A addr 5 = 0x0505/0x0505 on the same cycle as a read of bank B addr 5 previously holding 0x7777/0x7777 -> read returns 0x7777.
  - After the next swap, a read of addr 5 returns 0x0505.
- Held swap_req:
  - swap_req held high for 6 cycles -> swap_ack pulses on alternating cycles (3 pulses); wr_bank ends at 1 starting from 0.
- Bit-reverse, CRAM_BITREV_EN, N=8:
  - bitrev_wr=1, wr_addr=1 (001) with {0x00AA,0x0055}, then swap, then read addr 4 (100) -> 0x00AA/0x0055.
  - Read of addr 1 does not return this data.
